// File: rtl/gray_code_counter.sv
// Reflected-binary code source on a valid/ready stream.
// A binary count is advanced per accepted word and its Gray image is registered on o_g.
module gray_code_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_bin,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_g,
  output logic             o_valid,
  output logic             o_wrap
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;

  logic             w_accept;
  logic [WIDTH-1:0] w_cnt_adv;
  logic             w_cross;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A word is on offer exactly while in RUN, so accept needs only ready there.
  assign w_accept  = (r_state == S_RUN) && i_ready;
  assign w_cnt_adv = i_up_dn ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
  assign w_cross   = i_up_dn ? (r_cnt == {WIDTH{1'b1}}) : (r_cnt == {WIDTH{1'b0}});

  // State, count and all outputs move together so g always mirrors cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      o_g     <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_cnt  <= i_load_bin;
            o_g    <= to_gray(i_load_bin);
            o_wrap <= 1'b0;
          end
          if (i_en) begin
            r_state <= S_RUN;
            o_valid <= 1'b1;
          end
        end
        S_RUN: begin
          // Stalled words are held untouched; en and load only act on accept.
          if (w_accept) begin
            if (i_load) begin
              r_cnt  <= i_load_bin;
              o_g    <= to_gray(i_load_bin);
              o_wrap <= 1'b0;
            end else begin
              r_cnt  <= w_cnt_adv;
              o_g    <= to_gray(w_cnt_adv);
              o_wrap <= w_cross;
            end
            if (!i_en) begin
              r_state <= S_IDLE;
              o_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: directed steps then random traffic against
// an index-based model whose Gray words come from a reflection-built table.
module tb_gray_code_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NCODE = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic             ready;
  logic [WIDTH-1:0] g;
  logic             valid;
  logic             wrap;

  gray_code_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_up_dn    (up_dn),
    .i_load     (load),
    .i_load_bin (load_bin),
    .i_ready    (ready),
    .o_g        (g),
    .o_valid    (valid),
    .o_wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Model: position in the code sequence, run flag, wrap flag.
  logic [WIDTH-1:0] gray_tab [NCODE];
  int               m_idx;
  bit               m_run;
  bit               m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_table();
    int n;
    gray_tab[0] = '0;
    gray_tab[1] = WIDTH'(1);
    n = 2;
    // Reflect the list so far and prefix the mirrored half with the next bit.
    while (n < int'(NCODE)) begin
      for (int i = 0; i < n; i++)
        gray_tab[n + i] = gray_tab[n - 1 - i] | WIDTH'(n);
      n = n * 2;
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_run  = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (load) begin
        m_idx  = int'(load_bin);
        m_wrap = 1'b0;
      end
      if (en) m_run = 1'b1;
    end else if (ready) begin
      if (load) begin
        m_idx  = int'(load_bin);
        m_wrap = 1'b0;
      end else if (up_dn) begin
        m_wrap = (m_idx == int'(NCODE) - 1);
        m_idx  = (m_idx + 1) % int'(NCODE);
      end else begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + int'(NCODE) - 1) % int'(NCODE);
      end
      m_run = en;
    end
  endtask

  task automatic tick(input string tag);
    logic [WIDTH-1:0] prev_g;
    bit               adv;
    prev_g = g;
    adv    = m_run && ready && !load;
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_valid"}, 32'(valid), 32'(m_run));
    chk({tag, "_g"}, 32'(g), 32'(gray_tab[m_idx]));
    if (m_run) chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    if (adv) chk({tag, "_hamming"}, 32'($countones(g ^ prev_g)), 32'd1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_bin = '0;
    ready    = 1'b0;
    build_table();
    model_reset();

    // Reset and idle with en low.
    #12;
    rst_n = 1'b1;
    chk("rst_g", 32'(g), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    for (int i = 0; i < 5; i++) tick("idle");

    // Full up sequence with ready tied high, ending in a wrap.
    en    = 1'b1;
    ready = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 17; i++) tick("up");
    chk("upwrap_g", 32'(g), 32'h0);
    chk("upwrap_flag", 32'(wrap), 32'd1);

    // Backpressure on 0011 with en dropped during the stall.
    tick("up");
    tick("up");
    chk("bp_start_g", 32'(g), 32'h3);
    ready = 1'b0;
    en    = 1'b0;
    up_dn = 1'b0;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall_g", 32'(g), 32'h3);
    chk("stall_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    up_dn = 1'b1;
    tick("bp_accept");
    chk("bp_accept_valid", 32'(valid), 32'd0);
    en = 1'b1;
    tick("resume");
    chk("resume_g", 32'(g), 32'h2);

    // Load from IDLE together with en.
    en = 1'b0;
    tick("to_idle");
    load     = 1'b1;
    load_bin = 4'b0101;
    en       = 1'b1;
    tick("load");
    chk("load_g", 32'(g), 32'h7);
    chk("load_wrap", 32'(wrap), 32'd0);
    load = 1'b0;
    tick("load_adv");
    chk("load_adv_g", 32'(g), 32'h5);

    // Down wrap from zero.
    load     = 1'b1;
    load_bin = '0;
    up_dn    = 1'b0;
    tick("dn_load");
    chk("dn_load_g", 32'(g), 32'h0);
    load = 1'b0;
    tick("dn");
    chk("dnwrap_g", 32'(g), 32'h8);
    chk("dnwrap_flag", 32'(wrap), 32'd1);
    tick("dn");
    chk("dn2_g", 32'(g), 32'h9);
    chk("dn2_wrap", 32'(wrap), 32'd0);

    // Asynchronous reset between edges while 1101 is presented.
    load     = 1'b1;
    load_bin = 4'd9;
    tick("pre_rst");
    chk("pre_rst_g", 32'(g), 32'hd);
    load  = 1'b0;
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_g", 32'(g), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    ready = 1'b1;
    up_dn = 1'b1;
    tick("restart");
    chk("restart_g", 32'(g), 32'h0);
    chk("restart_valid", 32'(valid), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      up_dn    = 1'($urandom);
      ready    = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_bin = WIDTH'($urandom);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
